// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display path. The display decoder
// and the readback transmitter both import this package.
//   - active-low segment patterns for hex digits 0..F, plus the blank pattern
//   - ASCII byte constants used by the readback stream
//   - readback FSM state encoding
//   - seg_to_ascii(): recovered digit -> ASCII byte
// Segment bit order: bit6=g .. bit0=a, a lit segment is 0.
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_PAT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [6:0] SEG_BLANK   = 7'h7F;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEND_DIGIT = 3'd1,
        ST_SEND_CR    = 3'd2,
        ST_SEND_LF    = 3'd3,
        ST_DONE       = 3'd4
    } seg_state_e;

    // Anything neither hex nor blank becomes '?'.
    function automatic logic [7:0] seg_to_ascii(input logic [3:0] nibble,
                                                input logic       is_hex,
                                                input logic       is_blank);
        logic [7:0] r_byte;
        if (is_hex) begin
            if (nibble < 4'd10) r_byte = ASCII_0 + {4'h0, nibble};
            else                r_byte = ASCII_A + {4'h0, nibble} - 8'd10;
        end else if (is_blank) begin
            r_byte = ASCII_SPACE;
        end else begin
            r_byte = ASCII_QMARK;
        end
        return r_byte;
    endfunction

endpackage

// File: rtl/seg_readback_tx_if.sv
// -----------------------------------------------------------------------------
// seg_readback_tx_if
// Valid/ready byte stream from the readback block to the UART transmitter.
//   tx_data  : byte offered by the master
//   tx_valid : tx_data is valid
//   tx_ready : slave accepts tx_data on this clock edge
// -----------------------------------------------------------------------------
interface seg_readback_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/seg_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg_pattern_decode
// Combinational inverse of the hex display decoder.
//   i_pattern  : 7-bit active-low segment pattern
//   o_nibble   : recovered hex value (0 when not a hex pattern)
//   o_is_hex   : pattern matches one of the 16 hex glyphs
//   o_is_blank : pattern is all segments off
// -----------------------------------------------------------------------------
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_is_hex,
    output logic       o_is_blank
);

    always_comb begin
        o_nibble   = 4'h0;
        o_is_hex   = 1'b0;
        o_is_blank = (i_pattern == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (i_pattern == SEG_PAT[i]) begin
                o_nibble = 4'(i);
                o_is_hex = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_readback_tx.sv
// -----------------------------------------------------------------------------
// seg_readback_tx
// Captures the active-low segment patterns of NUM_DIGITS displays and streams
// the displayed hex digits as ASCII, most significant digit first, optionally
// followed by CR LF, so the host can read back what the board shows.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle frame request, ignored while busy
//   seg_in     : display patterns, digit k at [7k+6:7k]
//   tx         : valid/ready byte stream (master side)
//   busy       : frame in progress, start acceptance through done cycle
//   done       : one-cycle pulse after the last byte transfers
//   err        : some digit of the last frame was unrecognised
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for start
// SEND_DIGIT | offering the ASCII byte of digit r_idx
// SEND_CR    | offering CR
// SEND_LF    | offering LF
// DONE       | done pulse, tx_valid low
// -----------------------------------------------------------------------------
module seg_readback_tx
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter bit SEND_CRLF  = 1'b1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    seg_readback_tx_if.master       tx,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    seg_state_e              r_state, w_nxt_state;
    logic [7*NUM_DIGITS-1:0] r_snap, w_nxt_snap;
    logic [IDX_W-1:0]        r_idx, w_nxt_idx;
    logic [7:0]              r_tx_data, w_nxt_data;
    logic                    r_tx_valid, w_nxt_valid;
    logic                    r_err, w_nxt_err;

    logic [6:0]              w_snap_dig [NUM_DIGITS];
    logic [IDX_W-1:0]        w_sel;
    logic [6:0]              w_pat;
    logic [3:0]              w_nibble;
    logic                    w_is_hex;
    logic                    w_is_blank;
    logic                    w_ok;
    logic [7:0]              w_ascii;
    logic                    w_xfer;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        assign w_snap_dig[k] = r_snap[7*k +: 7];
    end

    // tx_data is registered, so the decoder always looks one byte ahead: in
    // IDLE at the live top digit (captured on the same edge), otherwise at the
    // snapshot digit that follows the one currently on the bus.
    assign w_sel = r_idx - IDX_W'(1);
    assign w_pat = (r_state == ST_IDLE) ? seg_in[7*(NUM_DIGITS-1) +: 7]
                                        : w_snap_dig[w_sel];

    seg_pattern_decode u_decode (
        .i_pattern  (w_pat),
        .o_nibble   (w_nibble),
        .o_is_hex   (w_is_hex),
        .o_is_blank (w_is_blank)
    );

    assign w_ok    = w_is_hex | w_is_blank;
    assign w_ascii = seg_to_ascii(w_nibble, w_is_hex, w_is_blank);
    assign w_xfer  = r_tx_valid & tx.tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_snap     <= '0;
            r_idx      <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_snap     <= w_nxt_snap;
            r_idx      <= w_nxt_idx;
            r_tx_data  <= w_nxt_data;
            r_tx_valid <= w_nxt_valid;
            r_err      <= w_nxt_err;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_snap  = r_snap;
        w_nxt_idx   = r_idx;
        w_nxt_data  = r_tx_data;
        w_nxt_valid = r_tx_valid;
        w_nxt_err   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nxt_state = ST_SEND_DIGIT;
                    w_nxt_snap  = seg_in;
                    w_nxt_idx   = IDX_W'(NUM_DIGITS - 1);
                    w_nxt_data  = w_ascii;
                    w_nxt_valid = 1'b1;
                    w_nxt_err   = ~w_ok;
                end
            end
            ST_SEND_DIGIT: begin
                if (w_xfer) begin
                    if (r_idx == '0) begin
                        if (SEND_CRLF) begin
                            w_nxt_state = ST_SEND_CR;
                            w_nxt_data  = ASCII_CR;
                        end else begin
                            w_nxt_state = ST_DONE;
                            w_nxt_data  = 8'h00;
                            w_nxt_valid = 1'b0;
                        end
                    end else begin
                        w_nxt_idx  = w_sel;
                        w_nxt_data = w_ascii;
                        w_nxt_err  = r_err | ~w_ok;
                    end
                end
            end
            ST_SEND_CR: begin
                if (w_xfer) begin
                    w_nxt_state = ST_SEND_LF;
                    w_nxt_data  = ASCII_LF;
                end
            end
            ST_SEND_LF: begin
                if (w_xfer) begin
                    w_nxt_state = ST_DONE;
                    w_nxt_data  = 8'h00;
                    w_nxt_valid = 1'b0;
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_valid = 1'b0;
            end
        endcase
    end

    assign tx.tx_data  = r_tx_data;
    assign tx.tx_valid = r_tx_valid;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign err         = r_err;

endmodule

// File: tb/tb_seg_readback_tx.sv
// -----------------------------------------------------------------------------
// tb_seg_readback_tx
// Self-checking bench for seg_readback_tx (NUM_DIGITS=4, SEND_CRLF=1).
// Expected bytes come from a table-lookup model of the displayed glyphs.
// -----------------------------------------------------------------------------
module tb_seg_readback_tx;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [27:0] seg_in;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    seg_readback_tx_if bif ();

    seg_readback_tx #(.NUM_DIGITS(4), .SEND_CRLF(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .seg_in (seg_in),
        .tx     (bif.master),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [7:0] exp_q [$];
    logic       exp_err;
    logic       exp_err0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What the host should receive for a given set of displayed patterns.
    function automatic void model(input logic [27:0] segs);
        exp_q.delete();
        exp_err  = 1'b0;
        exp_err0 = 1'b0;
        for (int d = 3; d >= 0; d--) begin
            logic [6:0] p;
            int         v;
            p = segs[7*d +: 7];
            v = -1;
            for (int k = 0; k < 16; k++) if (glyph[k] == p) v = k;
            if (v >= 0 && v < 10)      exp_q.push_back(8'(48 + v));
            else if (v >= 10)          exp_q.push_back(8'(65 + v - 10));
            else if (p == 7'h7F)       exp_q.push_back(8'h20);
            else begin
                exp_q.push_back(8'h3F);
                exp_err = 1'b1;
                if (d == 3) exp_err0 = 1'b1;
            end
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // mode 0: ready always 1; 1: random ready; 2: 5-cycle stall on byte 2.
    // poke: start pulses while busy (mid-frame and on done) and seg_in changes.
    task automatic run_frame(input logic [27:0] segs, input int mode, input bit poke);
        int         n_xfer;
        int         stall;
        bit         hold;
        bit         got_done;
        logic [7:0] prev_d;
        model(segs);
        @(negedge clk);
        start  = 1'b1;
        seg_in = segs;
        @(negedge clk);
        start = 1'b0;
        chk("latency1_valid", bif.tx_valid, 1'b1);
        chk("busy_on_accept", busy, 1'b1);
        chk("err_cleared_on_start", err, exp_err0);
        if (poke) seg_in = ~segs ^ 28'h0A5_5A5A;
        n_xfer   = 0;
        stall    = 0;
        hold     = 1'b0;
        got_done = 1'b0;
        prev_d   = 8'h00;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (hold) begin
                chk("stall_valid_stable", bif.tx_valid, 1'b1);
                chk("stall_data_stable", bif.tx_data, prev_d);
            end
            if (n_xfer == exp_q.size()) begin
                chk("done_pulse", done, 1'b1);
                chk("done_valid_low", bif.tx_valid, 1'b0);
                chk("done_busy", busy, 1'b1);
                chk("done_err", err, exp_err);
                start    = poke;
                got_done = 1'b1;
            end else begin
                if (mode == 0) chk("back_to_back_valid", bif.tx_valid, 1'b1);
                chk("no_early_done", done, 1'b0);
                case (mode)
                    0:       bif.tx_ready = 1'b1;
                    1:       bif.tx_ready = ($urandom_range(0, 3) != 0);
                    default: begin
                        if (n_xfer == 1 && bif.tx_valid && stall < 5) begin
                            bif.tx_ready = 1'b0;
                            stall++;
                        end else begin
                            bif.tx_ready = 1'b1;
                        end
                    end
                endcase
                start = poke && (cyc == 2);
                if (bif.tx_valid && bif.tx_ready) begin
                    chk($sformatf("byte%0d", n_xfer), bif.tx_data, exp_q[n_xfer]);
                    n_xfer++;
                end
                hold   = bif.tx_valid && !bif.tx_ready;
                prev_d = bif.tx_data;
            end
        end
        chk("frame_completed", got_done, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("idle_after_done", busy, 1'b0);
        chk("done_one_cycle", done, 1'b0);
        chk("err_held", err, exp_err);
        if (poke) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("no_queued_frame", bif.tx_valid | busy, 1'b0);
            end
        end
    endtask

    initial begin
        logic [27:0] segs;
        rst_n        = 1'b0;
        start        = 1'b0;
        seg_in       = '0;
        bif.tx_ready = 1'b1;
        #12;
        chk("rst_tx_valid", bif.tx_valid, 1'b0);
        chk("rst_tx_data", bif.tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_without_start", bif.tx_valid | busy, 1'b0);
        end

        run_frame({7'h79, 7'h24, 7'h30, 7'h19}, 0, 1'b0);
        run_frame({7'h08, 7'h03, 7'h46, 7'h0E}, 0, 1'b0);
        run_frame({7'h79, 7'h24, 7'h30, 7'h19}, 2, 1'b0);
        run_frame({7'h40, 7'h40, 7'h55, 7'h7F}, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_held_idle", err, 1'b1);
        end
        run_frame({7'h12, 7'h02, 7'h78, 7'h21}, 0, 1'b1);

        // Reset after two bytes, then a fresh complete frame.
        @(negedge clk);
        bif.tx_ready = 1'b1;
        start        = 1'b1;
        seg_in       = {7'h79, 7'h24, 7'h30, 7'h19};
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_valid", bif.tx_valid, 1'b0);
        chk("midrst_tx_data", bif.tx_data, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_err", err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_resume_after_reset", bif.tx_valid | busy, 1'b0);
        end
        run_frame({7'h79, 7'h24, 7'h30, 7'h19}, 0, 1'b0);

        for (int f = 0; f < 6; f++) begin
            for (int d = 0; d < 4; d++) begin
                if ($urandom_range(0, 3) != 0) segs[7*d +: 7] = glyph[$urandom_range(0, 15)];
                else                           segs[7*d +: 7] = 7'($urandom);
            end
            run_frame(segs, 1, 1'(f % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_readback_tx.md
Name: seg_readback_tx

Overview:
Inverse path of the HEX display decoder. Snapshots the active-low seven-segment patterns driving NUM_DIGITS displays and recovers each displayed hex digit. Streams the digits as ASCII bytes, most significant digit first, over a valid/ready byte interface to the UART transmitter. This lets the host read back exactly what the board is showing.

Parameters:
NUM_DIGITS, 4, number of display digits captured per frame (1..8)
SEND_CRLF, 1, when 1 append 0x0D 0x0A after the digits; when 0 send digits only

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to capture and send a frame; ignored while busy
seg_in  input  7*NUM_DIGITS  display patterns; digit k at bits [7k+6:7k]; bit6=g .. bit0=a; active-low
tx_data  output  8  ASCII byte offered to the transmitter
tx_valid  output  1  tx_data is valid
tx_ready  input  1  transmitter accepts tx_data this cycle
busy  output  1  frame in progress, from start acceptance through the done cycle
done  output  1  one-cycle pulse after the last byte is transferred
err  output  1  at least one digit in the last frame was unrecognised; valid from done until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n is low, tx_data=0x00 and tx_valid, busy, done, err are all 0. State returns to IDLE; the snapshot and digit index are cleared.
- States: IDLE -> SEND_DIGIT -> (SEND_CR -> SEND_LF, if SEND_CRLF) -> DONE -> IDLE.
- IDLE: when start=1, capture seg_in into the snapshot register, set index=NUM_DIGITS-1, set busy=1 and clear err. In the next cycle (latency 1), tx_valid=1 with the first byte.
- Decode table (active-low patterns):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78
  - 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E
- ASCII mapping:
  - 0-9 -> 0x30-0x39.
  - A-F -> 0x41-0x46 (uppercase).
  - Blank 0x7F -> 0x20 (space); not an error.
  - Any other pattern -> 0x3F ('?') and err is set for the frame.
- Handshake:
  - A byte transfers on any rising edge where tx_valid and tx_ready are both 1.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid stay stable.
  - tx_valid never drops without a transfer, except on reset.
  - With tx_ready held at 1, bytes go out back-to-back with no idle cycle.
- SEND_DIGIT: on transfer, if index=0 move to SEND_CR (SEND_CRLF=1) or DONE; otherwise decrement index and present the next byte in the next cycle.
- SEND_CR / SEND_LF: send 0x0D, then 0x0A, using the same handshake.
- DONE: tx_valid=0, done=1 for exactly one cycle with err final. Next cycle: IDLE, busy=0.
- Frame length is NUM_DIGITS + 2*SEND_CRLF bytes.
- start while busy, including the done cycle, is dropped and not queued.
- Changes to seg_in after capture do not affect the frame in flight.
- Reset mid-frame aborts immediately; no partial frame resumes. The next start sends a complete frame.
- The snapshot is registered; decode is combinational from the snapshot and index; tx_data is registered.

Decomposition:
- Shared package/include seg_pkg holds:
  - the 16 segment pattern constants and SEG_BLANK=7'h7F;
  - ASCII constants: CR, LF, SPACE, QMARK, '0', 'A';
  - the state encoding.
- The same package is reused by the existing display decoder.
- Sub-module seg_pattern_decode: combinational; 7-bit pattern in; nibble[3:0], is_hex and is_blank out. Instantiated once, muxed by index.

Test Plan:
- Reset: hold rst_n=0 mid-stream -> tx_valid=0, busy=0, done=0, err=0, tx_data=0x00 asynchronously. After release, the FSM stays idle until start.
- Digits 3..0 = 0x79,0x24,0x30,0x19, start, tx_ready=1 -> tx_valid rises 1 cycle after start. Bytes 0x31,0x32,0x33,0x34,0x0D,0x0A on consecutive cycles, then done pulse, err=0.
- Digits = 0x08,0x03,0x46,0x0E -> 0x41,0x42,0x43,0x46,0x0D,0x0A.
- Backpressure: same frame, tx_ready=0 for 5 cycles at byte 2 -> tx_data=0x32 and tx_valid=1 stable throughout. No byte lost or duplicated.
- Digits = 0x40,0x40,0x55,0x7F -> 0x30,0x30,0x3F,0x20,0x0D,0x0A; err=1 at done, held until the next start.
- start pulsed while busy, and seg_in changed after capture -> no second frame; bytes reflect the captured values. Reset after 2 bytes, then start -> full 6-byte frame from the first digit.
